// File: rtl/alu_mul_seq.sv
// Purpose : 32x32 unsigned shift-and-add multiplier that borrows the shared ALU as its only adder.
// Latency : done pulses WIDTH+2 edges after the accepting start edge (early-termination build: MSB-dependent).
// Backpressure: start is accepted only in IDLE or DONE; start while busy is ignored, product holds until the next completion.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   start                    multiply request (sampled in IDLE/DONE only)
//   multiplicand, multiplier operands, captured on the accepting edge
//   busy                     high while in LOAD or STEP
//   done                     one-cycle pulse, product valid
//   product                  2*WIDTH result, held until the next completion
//   alu_src1/alu_src2        ALU operands (owned by this block during STEP)
//   alu_ctrl                 {A_invert, B_invert, op[1:0]}: add in STEP, AND otherwise
//   alu_bonus                ALU bonus control, tied to zero
//   alu_result, alu_cout     combinational ALU response, consumed the same cycle
//
// Optional build macro: ALU_MUL_EARLY_TERM_EN
//   Finishes as soon as the unconsumed multiplier bits are all zero and realigns
//   the partial product with a barrel shifter.

module alu_mul_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_src1,
  output logic [WIDTH-1:0]     alu_src2,
  output logic [3:0]           alu_ctrl,
  output logic [2:0]           alu_bonus,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;

  logic             load_ops;
  logic             step_en;
  logic             cap_en;
  logic             last_step;

  logic [WIDTH-1:0]   hi_step;
  logic [WIDTH-1:0]   lo_step;
  logic [2*WIDTH-1:0] prod_nxt;

  // {hi,lo} <= {cout, sum, lo} >> 1: the add carry becomes hi's MSB, the
  // sum's LSB drops into lo as the multiplier bit just consumed shifts out.
  assign hi_step = {alu_cout, alu_result[WIDTH-1:1]};
  assign lo_step = {alu_result[0], lo[WIDTH-1:1]};

  assign alu_bonus = 3'b000;

`ifdef ALU_MUL_EARLY_TERM_EN
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W:0]   shamt;
  logic [WIDTH-1:0] rem_mask;
  logic             rem_zero_step;

  assign cnt_inc  = {1'b0, cnt} + 1'b1;
  // After this step the low WIDTH-cnt-1 bits of (lo >> 1) are the multiplier
  // bits not yet consumed; if they are all zero the remaining adds are no-ops.
  assign rem_mask      = {WIDTH{1'b1}} >> cnt_inc;
  assign rem_zero_step = (((lo >> 1) & rem_mask) == '0);
  assign last_step     = (cnt == CNT_W'(WIDTH-1)) || rem_zero_step;
  // Only cnt_inc steps ran, so the product sits WIDTH-cnt_inc bits too high.
  assign shamt         = (CNT_W+1)'(WIDTH) - cnt_inc;

  always_comb begin
    prod_nxt = {hi_step, lo_step} >> shamt;
    // Terminating from LOAD means zero steps: {hi,lo} >> WIDTH, and hi is 0.
    if (state == S_LOAD) begin
      prod_nxt = {{WIDTH{1'b0}}, hi};
    end
  end
`else
  assign last_step = (cnt == CNT_W'(WIDTH-1));
  assign prod_nxt  = {hi_step, lo_step};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_src1  = '0;
    alu_src2  = '0;
    alu_ctrl  = ALU_AND;
    load_ops  = 1'b0;
    step_en   = 1'b0;
    cap_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load_ops  = 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        busy      = 1'b1;
        state_nxt = S_STEP;
`ifdef ALU_MUL_EARLY_TERM_EN
        if (lo == '0) begin
          cap_en    = 1'b1;
          state_nxt = S_DONE;
        end
`endif
      end
      S_STEP: begin
        busy     = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_src1 = hi;
        alu_src2 = lo[0] ? mcand : '0;
        step_en  = 1'b1;
        if (last_step) begin
          cap_en    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          load_ops  = 1'b1;
          state_nxt = S_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (load_ops) begin
        mcand <= multiplicand;
        lo    <= multiplier;
        hi    <= '0;
        cnt   <= '0;
      end else if (step_en) begin
        hi  <= hi_step;
        lo  <= lo_step;
        cnt <= cnt + 1'b1;
      end
      if (cap_en) begin
        product <= prod_nxt;
      end
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Purpose : self-checking bench for alu_mul_seq with a behavioural ALU and a product/latency reference.
// Latency : expected done latency derived from operand values (fixed or MSB-dependent build).
// Backpressure: exercises ignored start while busy, held start for back-to-back, and mid-operation reset.

module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_bonus;
  logic [31:0] alu_result;
  logic        alu_cout;

`ifdef ALU_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .alu_ctrl     (alu_ctrl),
    .alu_bonus    (alu_bonus),
    .alu_result   (alu_result),
    .alu_cout     (alu_cout)
  );

  // Combinational shared ALU: AND, OR, ADD with carry out.
  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_src1 & alu_src2;
      4'b0001: alu_result = alu_src1 | alu_src2;
      4'b0010: {alu_cout, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Edges from the accepting start edge up to and including the edge after
  // which done is high.
  function automatic int exp_lat(input logic [31:0] b);
    int m;
    m = -1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) m = i;
    end
    return EARLY ? (m + 3) : 34;
  endfunction

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
    int          lat;
    int          busy_cyc;
    logic        ctrl_seen;
    logic        bonus_bad;
    logic [63:0] exp_p;
    exp_p = 64'(a) * 64'(b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    lat       = 1;
    busy_cyc  = 0;
    ctrl_seen = 1'b0;
    bonus_bad = 1'b0;
    while (!done && lat < 100) begin
      if (busy) busy_cyc++;
      if (alu_ctrl != 4'b0000) ctrl_seen = 1'b1;
      if (alu_bonus != 3'b000) bonus_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " done_seen"}, 64'(done), 64'd1);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat(b)));
    chk({tag, " busy_cycles"}, 64'(busy_cyc), 64'(exp_lat(b) - 1));
    chk({tag, " product"}, product, exp_p);
    chk({tag, " bonus"}, 64'(bonus_bad), 64'd0);
`ifdef ALU_MUL_EARLY_TERM_EN
    if (b == 32'd0) chk({tag, " ctrl_idle"}, 64'(ctrl_seen), 64'd0);
`endif
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " product_held"}, product, exp_p);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          pulses;
    int          n;
    int          ign;
    int          rst_at;
    logic [31:0] ra;
    logic [31:0] rb;

    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset product", product, 64'd0);
    chk("reset alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("reset alu_src", {alu_src1, alu_src2}, 64'd0);
    chk("reset alu_bonus", 64'(alu_bonus), 64'd0);
    rst = 1'b0;

    do_mul(32'd5, 32'd3, "5x3");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max_x_max");

    // Start while busy must be ignored.
    ign = EARLY ? 2 : 10;
    @(negedge clk);
    multiplicand = 32'd7;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    pulses = 0;
    for (int c = 1; c < 45; c++) begin
      if (c == ign) begin
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        start        = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) pulses++;
    end
    chk("ignore pulses", 64'(pulses), 64'd1);
    chk("ignore product", product, 64'h3F);

    // Reset mid-operation aborts with no done.
    rst_at = EARLY ? 2 : 15;
    @(negedge clk);
    multiplicand = 32'd6;
    multiplier   = 32'd7;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < rst_at; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst product", product, 64'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("midrst no_activity", 64'(pulses), 64'd0);
    do_mul(32'd6, 32'd7, "6x7_after_rst");

    // Start held high: back-to-back multiplies, operands change on done.
    @(negedge clk);
    multiplicand = 32'd3;
    multiplier   = 32'd4;
    start        = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b first latency", 64'(n), 64'(exp_lat(32'd4)));
    chk("b2b first product", product, 64'h0C);
    multiplicand = 32'd10;
    multiplier   = 32'd10;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 100);
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    chk("b2b gap", 64'(n), 64'(exp_lat(32'd10)));
    chk("b2b second product", product, 64'h64);
    @(posedge clk); #1;
    chk("b2b stop", 64'(busy | done), 64'd0);

    do_mul($urandom, 32'd0, "mult_zero");
    do_mul(32'd0, $urandom, "mcand_zero");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 3 != 0) rb = rb >> $urandom_range(0, 31);
      do_mul(ra, rb, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
